// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the core: word-addressed data RAM with byte enables,
// plus an MMIO block holding a console TX FIFO, a sticky DONE flag and a cycle counter.
module dmem_mmio_responder #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    input  logic [3:0]  dmem_we,
    input  logic        dmem_en,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE   = {{PW{1'b0}}, 1'b1};
    localparam logic [31:0] CYCLE_ONE = 32'd1;

    typedef enum logic [1:0] {
        REG_TX_DATA = 2'd0,
        REG_STATUS  = 2'd1,
        REG_DONE    = 2'd2,
        REG_CYCLE   = 2'd3
    } mmio_reg_t;

    logic [31:0] ram [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         overflow;
    logic [31:0]  cycle;

    logic [AW-1:0] word_idx;
    mmio_reg_t     mmio_reg;
    logic          ram_sel;
    logic          mmio_sel;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          overflow_clr;
    logic          done_wr;
    logic [31:0]   status;
    logic          unused_addr_lsb;

    // Byte lane bits never matter: RAM is word-wide and MMIO registers are word-aligned.
    assign unused_addr_lsb = ^dmem_addr[1:0];

    assign word_idx = dmem_addr[AW+1:2];
    assign mmio_reg = mmio_reg_t'(dmem_addr[3:2]);
    assign ram_sel  = dmem_en && (dmem_addr[31:AW+2] == '0);
    assign mmio_sel = dmem_en && !ram_sel && (dmem_addr[31:4] == MMIO_BASE[31:4]);

    // The extra wrap bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign push_req     = mmio_sel && (mmio_reg == REG_TX_DATA) && dmem_we[0];
    assign push         = push_req && !fifo_full;
    assign pop          = !fifo_empty && tx_ready;
    assign overflow_clr = mmio_sel && (mmio_reg == REG_STATUS) && dmem_we[0] && dmem_wdata[3];
    assign done_wr      = mmio_sel && (mmio_reg == REG_DONE) && (dmem_we != 4'b0000);

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_mem[rd_ptr[PW-1:0]];
    assign status   = {28'b0, overflow, done, fifo_full, fifo_empty};

    always_ff @(posedge clk) begin
        if (ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_we[i]) begin
                    ram[word_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= dmem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            cycle    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // A dropped byte outranks a clear landing on the same edge.
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
            if (done_wr) begin
                done <= 1'b1;
            end
            if (!done) begin
                cycle <= cycle + CYCLE_ONE;
            end
        end
    end

    always_comb begin
        dmem_rdata = '0;
        if (ram_sel) begin
            dmem_rdata = ram[word_idx];
        end else if (mmio_sel) begin
            unique case (mmio_reg)
                REG_TX_DATA: dmem_rdata = '0;
                REG_STATUS:  dmem_rdata = status;
                REG_DONE:    dmem_rdata = {31'b0, done};
                REG_CYCLE:   dmem_rdata = cycle;
                default:     dmem_rdata = '0;
            endcase
        end
    end

endmodule
